// File: rtl/nn_pkg.sv
// Shared definitions for the layer scheduler and the PU controller.
//   - 3-bit state encodings for the layer scheduler FSM
//   - default width of one PU output
package nn_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_START = ST_START,
    S_WAIT  = ST_WAIT,
    S_NEXT  = ST_NEXT,
    S_DONE  = ST_DONE
  } sched_state_t;

endpackage

// File: rtl/sched_lane_tracker.sv
// Sticky per-lane completion flags for one batch of PUs.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   clear           clears all flags (issued together with the PU start)
//   capture_en      high while the scheduler is waiting for results
//   lane_valid      lanes that carry a real neuron in this batch
//   pu_ready        per-PU ready
//   capture         one-cycle strobe per lane: store this lane's output now
//   all_done        every valid lane has been captured (registered flags)
module sched_lane_tracker
  import nn_pkg::*;
#(
  parameter int NUM_PU = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture_en,
  input  logic [NUM_PU-1:0] lane_valid,
  input  logic [NUM_PU-1:0] pu_ready,
  output logic [NUM_PU-1:0] capture,
  output logic              all_done
);

  logic [NUM_PU-1:0] flag_q, flag_d;

  // A flagged lane is never captured again, even if ready stays high.
  always_comb begin
    capture = {NUM_PU{capture_en}} & lane_valid & pu_ready & ~flag_q;
    flag_d  = flag_q;
    if (clear) flag_d = '0;
    else       flag_d = flag_q | capture;
  end

  // Invalid lanes count as done so a partial last batch can finish.
  assign all_done = &(flag_q | ~lane_valid);

  always_ff @(posedge clk) begin
    if (!rst) flag_q <= '0;
    else      flag_q <= flag_d;
  end

endmodule

// File: rtl/pu_layer_scheduler.sv
// Runs one MLP layer over a shared PU bank, NUM_PU neurons per batch.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   start        level request, honoured only when idle
//   pu_ready     per-PU ready; pu_out lane i at [i*DATA_W +: DATA_W]
//   pu_start     one-cycle broadcast start
//   batch_idx    current batch, used upstream to steer weight/bias ROMs
//   lane_valid   lane i maps to a neuron inside the layer
//   results      neuron n at [n*DATA_W +: DATA_W]
//   busy, done   not idle / one-cycle completion pulse
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | ROMs present data for batch_idx (1-cycle read latency)
// START   | pu_start pulse, lane flags cleared
// WAIT    | capture each valid lane once on its ready
// NEXT    | advance batch or finish
// DONE    | done pulse
module pu_layer_scheduler
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = 30,
  parameter int NUM_PU      = 10,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BATCH_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_PU-1:0]             pu_ready,
  input  logic [NUM_PU*DATA_W-1:0]      pu_out,
  output logic                          pu_start,
  output logic [BATCH_W-1:0]            batch_idx,
  output logic [NUM_PU-1:0]             lane_valid,
  output logic [NUM_NEURONS*DATA_W-1:0] results,
  output logic                          busy,
  output logic                          done
);

  localparam int NUM_BATCH = (NUM_NEURONS + NUM_PU - 1) / NUM_PU;
  localparam int LANE_W    = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
  localparam int IDX_W     = BATCH_W + LANE_W;
  localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(NUM_BATCH - 1);

  sched_state_t                  state_q, state_d;
  logic [BATCH_W-1:0]            batch_idx_q, batch_idx_d;
  logic [NUM_NEURONS*DATA_W-1:0] results_q, results_d;

  logic [NUM_PU-1:0] capture;
  logic              all_done;
  logic              flags_clear;
  logic              capture_en;
  logic [IDX_W-1:0]  neuron_idx [NUM_PU];

  // Compared one bit wider so NUM_NEURONS == 2**IDX_W cannot wrap.
  always_comb begin
    for (int i = 0; i < NUM_PU; i++) begin
      neuron_idx[i] = IDX_W'(batch_idx_q) * IDX_W'(NUM_PU) + IDX_W'(i);
      lane_valid[i] = {1'b0, neuron_idx[i]} < (IDX_W + 1)'(NUM_NEURONS);
    end
  end

  sched_lane_tracker #(.NUM_PU(NUM_PU)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (flags_clear),
    .capture_en (capture_en),
    .lane_valid (lane_valid),
    .pu_ready   (pu_ready),
    .capture    (capture),
    .all_done   (all_done)
  );

  always_comb begin
    state_d     = state_q;
    batch_idx_d = batch_idx_q;
    pu_start    = 1'b0;
    done        = 1'b0;
    flags_clear = 1'b0;
    capture_en  = 1'b0;
    busy        = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          batch_idx_d = '0;
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        pu_start    = 1'b1;
        flags_clear = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        capture_en = 1'b1;
        if (all_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (batch_idx_q == LAST_BATCH) begin
          state_d = S_DONE;
        end else begin
          batch_idx_d = batch_idx_q + 1'b1;
          state_d     = S_LOAD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Neuron n always comes from lane n%NUM_PU in batch n/NUM_PU, so each
  // result slot decodes its own write enable without an index adder.
  always_comb begin
    results_d = results_q;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (capture[n % NUM_PU] && (batch_idx_q == BATCH_W'(n / NUM_PU)))
        results_d[n*DATA_W +: DATA_W] = pu_out[(n % NUM_PU)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      batch_idx_q <= '0;
      results_q   <= '0;
    end else begin
      state_q     <= state_d;
      batch_idx_q <= batch_idx_d;
      results_q   <= results_d;
    end
  end

  assign batch_idx = batch_idx_q;
  assign results   = results_q;

endmodule

// File: tb/tb_pu_layer_scheduler.sv
module tb_pu_layer_scheduler;

  localparam int NP = 10;
  localparam int DW = 8;
  localparam int BW = 4;
  localparam int NA = 30;
  localparam int NB = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b;
  logic [NP-1:0] ready_a, ready_b, lv_a, lv_b;
  logic [NP*DW-1:0] out_a, out_b;
  logic ps_a, ps_b, busy_a, busy_b, done_a, done_b;
  logic [BW-1:0] bi_a, bi_b;
  logic [NA*DW-1:0] res_a;
  logic [NB*DW-1:0] res_b;

  pu_layer_scheduler #(.NUM_NEURONS(NA), .NUM_PU(NP), .DATA_W(DW), .BATCH_W(BW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pu_ready(ready_a), .pu_out(out_a),
    .pu_start(ps_a), .batch_idx(bi_a), .lane_valid(lv_a), .results(res_a),
    .busy(busy_a), .done(done_a));

  pu_layer_scheduler #(.NUM_NEURONS(NB), .NUM_PU(NP), .DATA_W(DW), .BATCH_W(BW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pu_ready(ready_b), .pu_out(out_b),
    .pu_start(ps_b), .batch_idx(bi_b), .lane_valid(lv_b), .results(res_b),
    .busy(busy_b), .done(done_b));

  // Behavioural PU bank, one per DUT: lane i answers lat[i] cycles after
  // pu_start, keeps ready high, and alters its output two cycles later.
  int         lat [2][NP];
  logic [7:0] data [2][160];
  logic [NP-1:0] never_last [2];
  int         cnt [2];
  bit         stale [2];
  bit         stale_clr [2];

  task automatic model_pu(input int d, input logic ps, input logic [BW-1:0] bi,
                          output logic [NP-1:0] rdy, output logic [NP*DW-1:0] o);
    int n;
    logic [7:0] v;
    if (ps) begin
      cnt[d] = 0;
      stale_clr[d] = 1'b1;
    end else begin
      if (cnt[d] < 1000) cnt[d]++;
      if (stale_clr[d]) begin
        stale[d] = 1'b0;
        stale_clr[d] = 1'b0;
      end
    end
    for (int i = 0; i < NP; i++) begin
      n = int'(bi) * NP + i;
      v = data[d][n];
      if (stale[d]) begin
        rdy[i] = 1'b1;
        o[i*DW +: DW] = 8'hEE;
      end else begin
        rdy[i] = !(never_last[d][i] && bi == 2) && (cnt[d] >= lat[d][i]);
        o[i*DW +: DW] = (cnt[d] >= lat[d][i] + 2) ? ~v : v;
      end
    end
  endtask

  always @(negedge clk) begin
    model_pu(0, ps_a, bi_a, ready_a, out_a);
    model_pu(1, ps_b, bi_b, ready_b, out_b);
  end

  // Event monitor.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int q_cyc_a[$], q_bi_a[$], q_cyc_b[$], q_bi_b[$];
  int done_cnt_a = 0, done_cyc_a = 0, done_cnt_b = 0, done_cyc_b = 0;
  logic [NP-1:0] lv_b_last = '0;

  always @(negedge clk) begin
    if (ps_a) begin q_cyc_a.push_back(cyc); q_bi_a.push_back(int'(bi_a)); end
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
    if (ps_b) begin
      q_cyc_b.push_back(cyc); q_bi_b.push_back(int'(bi_b));
      if (bi_b == 2) lv_b_last = lv_b;
    end
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_setup(input int d, input int lo, input int hi);
    for (int i = 0; i < NP; i++) lat[d][i] = $urandom_range(hi, lo);
    for (int n = 0; n < 160; n++) data[d][n] = 8'($urandom);
  endtask

  function automatic int max_lat(input int d, input int nl);
    int m = 0;
    for (int i = 0; i < nl; i++) if (lat[d][i] > m) m = lat[d][i];
    return m;
  endfunction

  function automatic logic [NA*DW-1:0] exp_a();
    logic [NA*DW-1:0] e;
    for (int n = 0; n < NA; n++) e[n*DW +: DW] = data[0][n];
    return e;
  endfunction

  function automatic logic [NB*DW-1:0] exp_b();
    logic [NB*DW-1:0] e;
    for (int n = 0; n < NB; n++) e[n*DW +: DW] = data[1][n];
    return e;
  endfunction

  // Batch order, batch spacing (4 + slowest lane) and the done position.
  task automatic check_run_a(input string tag, input int ml);
    chk({tag, " nstart"}, q_cyc_a.size(), 3);
    for (int k = 0; k < q_cyc_a.size() && k < 3; k++) begin
      chk({tag, " batch"}, q_bi_a[k], k);
      if (k > 0) chk({tag, " spacing"}, q_cyc_a[k] - q_cyc_a[k-1], 4 + ml);
    end
    if (q_cyc_a.size() >= 3) chk({tag, " done_gap"}, done_cyc_a - q_cyc_a[2], 3 + ml);
    chk({tag, " results"}, res_a, exp_a());
  endtask

  task automatic run_a(input string tag);
    int prev, ml;
    q_cyc_a.delete(); q_bi_a.delete();
    prev = done_cnt_a;
    ml = max_lat(0, NP);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 2000 && done_cnt_a == prev; k++) step();
    chk({tag, " done"}, done_cnt_a, prev + 1);
    check_run_a(tag, ml);
    step(); step();
    chk({tag, " busy_after"}, busy_a, 1'b0);
    chk({tag, " one_done"}, done_cnt_a, prev + 1);
  endtask

  initial begin
    int prev, d1, ml, dc;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 100; stale[d] = 1'b0; stale_clr[d] = 1'b0; never_last[d] = '0;
      for (int i = 0; i < NP; i++) lat[d][i] = 5;
      for (int n = 0; n < 160; n++) data[d][n] = 8'(n);
    end
    repeat (3) step();
    chk("rst busy", busy_a, 1'b0);
    chk("rst done", done_a, 1'b0);
    chk("rst pu_start", ps_a, 1'b0);
    chk("rst batch_idx", bi_a, 4'd0);
    chk("rst results", res_a, '0);
    chk("rst lane_valid", lv_a, 10'h3ff);
    chk("rst results_b", res_b, '0);
    rst = 1'b1;
    step();

    // Fixed latency 5, output = neuron index.
    run_a("t1");

    // Staggered readies lane i at 3+i, held high, output changes afterwards.
    rand_setup(0, 1, 1);
    for (int i = 0; i < NP; i++) lat[0][i] = 3 + i;
    run_a("t3");

    // Stale all-ones ready with junk data before the first pu_start.
    rand_setup(0, 1, 8);
    stale[0] = 1'b1;
    stale_clr[0] = 1'b0;
    step();
    run_a("t6");

    // Random latencies and data.
    for (int r = 0; r < 3; r++) begin
      rand_setup(0, 1, 10);
      run_a("rand");
    end

    // Partial last batch on the 25-neuron instance; lanes 5..9 of batch 2 silent.
    rand_setup(1, 1, 8);
    never_last[1] = 10'h3e0;
    prev = done_cnt_b;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 0; k < 2000 && done_cnt_b == prev; k++) step();
    chk("t2 done", done_cnt_b, prev + 1);
    chk("t2 nstart", q_cyc_b.size(), 3);
    chk("t2 lane_valid", lv_b_last, 10'h01f);
    if (q_cyc_b.size() >= 3) begin
      chk("t2 spacing1", q_cyc_b[1] - q_cyc_b[0], 4 + max_lat(1, NP));
      chk("t2 spacing2", q_cyc_b[2] - q_cyc_b[1], 4 + max_lat(1, NP));
      chk("t2 done_gap", done_cyc_b - q_cyc_b[2], 3 + max_lat(1, 5));
    end
    chk("t2 results", res_b, exp_b());

    // start held high: no restart mid-run, back-to-back run after DONE.
    rand_setup(0, 2, 7);
    ml = max_lat(0, NP);
    q_cyc_a.delete(); q_bi_a.delete();
    prev = done_cnt_a;
    start_a = 1'b1;
    for (int k = 0; k < 2000 && done_cnt_a == prev; k++) step();
    chk("t4 done1", done_cnt_a, prev + 1);
    d1 = done_cyc_a;
    check_run_a("t4 run1", ml);
    for (int k = 0; k < 50 && q_cyc_a.size() < 4; k++) step();
    chk("t4 restart_n", q_cyc_a.size(), 4);
    if (q_cyc_a.size() >= 4) begin
      chk("t4 restart_cyc", q_cyc_a[3], d1 + 3);
      chk("t4 restart_batch", q_bi_a[3], 0);
    end
    start_a = 1'b0;
    for (int k = 0; k < 2000 && done_cnt_a == prev + 1; k++) step();
    chk("t4 done2", done_cnt_a, prev + 2);
    chk("t4 results2", res_a, exp_a());
    step(); step();
    chk("t4 idle", busy_a, 1'b0);

    // Reset during WAIT of batch 1.
    rand_setup(0, 5, 5);
    q_cyc_a.delete(); q_bi_a.delete();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 200 && q_bi_a.size() < 2; k++) step();
    chk("t5 reached_b1", q_bi_a.size(), 2);
    step();
    dc = done_cnt_a;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t5 busy", busy_a, 1'b0);
    chk("t5 pu_start", ps_a, 1'b0);
    chk("t5 done", done_a, 1'b0);
    chk("t5 batch_idx", bi_a, 4'd0);
    chk("t5 results", res_a, '0);
    repeat (40) step();
    chk("t5 no_done", done_cnt_a, dc);
    chk("t5 still_idle", busy_a, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
